sram_like_resp: RTL and testbench
=================================

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the backing memory depth in 32-bit words.
REQ-002 SHALL have parameter RESP_DELAY, default 1, legal range 1..7, meaning cycles from request acceptance to data_ok.
REQ-003 SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, width 1, a synchronous active-high reset.
REQ-005 SHALL have port data_sram_req, input, width 1, meaning a request is presented.
REQ-006 SHALL have port data_sram_wr, input, width 1, where 1 is a write and 0 is a read.
REQ-007 SHALL have port data_sram_size, input, width 2, where 0 is byte, 1 is half and 2 is word; it is informational only.
REQ-008 SHALL have port data_sram_addr, input, width 32, the byte address.
REQ-009 SHALL have port data_sram_wstrb, input, width 4, the byte write enables.
REQ-010 SHALL have port data_sram_wdata, input, width 32, the write data, already lane-aligned by the initiator.
REQ-011 SHALL have port data_sram_addr_ok, output, width 1, meaning the request is accepted this cycle.
REQ-012 SHALL have port data_sram_data_ok, output, width 1, a one-cycle response pulse per accepted request.
REQ-013 SHALL have port data_sram_rdata, output, width 32, the full read word, valid only while data_ok=1.

Function
REQ-014 A request SHALL be accepted exactly in cycles where data_sram_req=1 and data_sram_addr_ok=1.
REQ-015 addr_ok SHALL be 1 iff outstanding count < 2 and reset=0, further gated per REQ-033 when RAND_DELAY_EN is defined; addr_ok may be 1 with req=0.
REQ-016 Word index SHALL be data_sram_addr[ADDR_W+1:2]; higher address bits and addr[1:0] SHALL be ignored.
REQ-017 An accepted write SHALL update the memory at the accepting edge, lane i only where wstrb[i]=1; wstrb=0000 SHALL leave memory unchanged but still get a response.
REQ-018 An accepted read SHALL capture the memory word at acceptance, after any write accepted in an earlier cycle, into its response entry.
REQ-019 Outstanding requests SHALL be held in a 2-entry in-order FIFO: valid, wr, rdata[31:0], countdown[2:0] per entry.
REQ-020 An entry SHALL be loaded with countdown=RESP_DELAY-1 (plus extra delay per REQ-034) and decrement by 1 each cycle while nonzero.
REQ-021 data_ok SHALL be 1 in a cycle iff the FIFO head is valid with countdown=0; that entry pops at the end of the cycle.
REQ-022 With no extra delay, a request accepted at edge N SHALL have data_ok high during cycle N+RESP_DELAY.
REQ-023 Responses SHALL be strictly in acceptance order; a non-head entry whose countdown reaches 0 SHALL wait at 0 until it becomes head.
REQ-024 rdata SHALL equal the entry's captured word for reads and 32'h0 for writes while data_ok=1, and 32'h0 while data_ok=0.
REQ-025 Simultaneous accept and pop SHALL leave the count unchanged; at RESP_DELAY=1 with no gating, sustained throughput SHALL be one request per cycle.
REQ-026 With the FIFO full, addr_ok SHALL be 0 even in a cycle where the head pops (no combinational path from pop to addr_ok).
REQ-027 data_ok SHALL have no backpressure; the initiator always consumes it.

Reset
REQ-028 While reset=1: FIFO empty, addr_ok=0, data_ok=0, rdata=32'h0, countdowns 0, LFSR=16'hACE1.
REQ-029 Reset mid-operation SHALL discard all outstanding requests; no data_ok SHALL appear for them after reset deasserts.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 A request presented during reset SHALL NOT be accepted and SHALL NOT write memory.

Configuration
REQ-032 Macro RAND_DELAY_EN SHALL enable pseudo-random timing; when undefined, no LFSR is built, timing is exactly REQ-015/REQ-022, and the extra delay is 0.
REQ-033 With RAND_DELAY_EN: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset, and addr_ok is additionally forced 0 when lfsr[1:0]=2'b00.
REQ-034 With RAND_DELAY_EN: extra delay = lfsr[3:2] (0..3 cycles), sampled at acceptance and added to the loaded countdown (saturating at 7); response order is still per REQ-023.

Verification
REQ-035 Write addr=0x10, wdata=0x11223344, wstrb=1111; then read 0x10 -> data_ok one cycle after each accept (RESP_DELAY=1); read rdata=0x11223344.
REQ-036 Memory word 0x10=0x11223344; write wdata=0xAABB0000, wstrb=1100; read 0x10 -> rdata=0xAABB3344.
REQ-037 req held high for 8 back-to-back reads, RESP_DELAY=1, macro undefined -> addr_ok high all 8 cycles; 8 data_ok pulses in consecutive cycles, in order.
REQ-038 RESP_DELAY=4, req held high -> two accepts, then addr_ok=0 until the first data_ok cycle; data_ok at cycles N+4 and N+5.
REQ-039 Two reads accepted, reset pulsed for one cycle before either data_ok -> no data_ok afterwards; addr_ok=0 during reset and 1 the cycle after.
REQ-040 RAND_DELAY_EN defined, 200 random reads and writes checked against a scoreboard -> every accept gets exactly one in-order data_ok; rdata matches the model; addr_ok is never 1 when lfsr[1:0]=00.

Source files
------------

// File: rtl/sram_like_resp.sv
// sram_like_resp: SRAM-like data-port responder with a 2-deep in-order response FIFO.
// Define RAND_DELAY_EN for LFSR-driven accept gating and extra response delay.
module sram_like_resp #(
    parameter int ADDR_W     = 10,
    parameter int RESP_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [1:0] vld_q, vld_d, wr_q, wr_d;
    logic [1:0][31:0] rd_q, rd_d;
    logic [1:0][2:0] cd_q, cd_d, cd_dec;
    logic [1:0] extra;
    logic [3:0] load_sum;
    logic [2:0] load_cd;
    logic gate_ok, accept, pop, slot;
    logic unused_bits;

    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    assign idx = data_sram_addr[ADDR_W+1:2];

`ifdef RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk)
        lfsr_q <= reset ? 16'hACE1 : lfsr_d;
    assign gate_ok = lfsr_q[1:0] != 2'b00;
    assign extra = lfsr_q[3:2];
`else
    assign gate_ok = 1'b1;
    assign extra = 2'd0;
`endif

    assign load_sum = 4'(RESP_DELAY - 1) + {2'b00, extra};
    assign load_cd = load_sum > 4'd7 ? 3'd7 : load_sum[2:0];
    // Full is decided from registered state only, so a same-cycle pop never reopens addr_ok
    assign data_sram_addr_ok = !reset && !vld_q[1] && gate_ok;
    assign accept = data_sram_req && data_sram_addr_ok;
    assign pop = !reset && vld_q[0] && cd_q[0] == 3'd0;
    assign data_sram_data_ok = pop;
    assign data_sram_rdata = (pop && !wr_q[0]) ? rd_q[0] : 32'h0;

    always_comb begin
        for (int i = 0; i < 2; i++)
            cd_dec[i] = cd_q[i] != 3'd0 ? cd_q[i] - 3'd1 : 3'd0;
        vld_d = pop ? {1'b0, vld_q[1]} : vld_q;
        wr_d  = pop ? {1'b0, wr_q[1]} : wr_q;
        rd_d  = pop ? {32'h0, rd_q[1]} : rd_q;
        cd_d  = pop ? {3'h0, cd_dec[1]} : cd_dec;
        slot  = vld_d[0];
        if (accept) begin
            vld_d[slot] = 1'b1;
            wr_d[slot]  = data_sram_wr;
            rd_d[slot]  = mem[idx];
            cd_d[slot]  = load_cd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cd_q  <= cd_d;
        end
    end

    // Memory is intentionally left out of reset
    always_ff @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (accept && data_sram_wr && data_sram_wstrb[b])
                mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: directed checks of sram_like_resp at RESP_DELAY 1 and 4, plus a scoreboarded random run.
module tb_sram_like_resp;
    logic clk = 1'b0, reset = 1'b1, req = 1'b0, wr = 1'b0;
    logic [1:0] size = 2'd2;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0] wstrb = '0;
    logic aok_a, dok_a, aok_b, dok_b;
    logic [31:0] rdata_a, rdata_b;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_like_resp #(.ADDR_W(10), .RESP_DELAY(1)) dut_a (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
        .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
        .data_sram_addr_ok(aok_a), .data_sram_data_ok(dok_a), .data_sram_rdata(rdata_a));

    sram_like_resp #(.ADDR_W(10), .RESP_DELAY(4)) dut_b (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
        .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
        .data_sram_addr_ok(aok_b), .data_sram_data_ok(dok_b), .data_sram_rdata(rdata_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) step();
    endtask

    task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req = r; wr = w; addr = a; wstrb = s; wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b1, 1'b1, 32'h80, 4'hF, 32'hDEADBEEF);
        step(); step();
        checks++; if (aok_a !== 1'b0) begin errors++; $display("FAIL rst_aok_a: got %b exp 0", aok_a); end
        checks++; if (aok_b !== 1'b0) begin errors++; $display("FAIL rst_aok_b: got %b exp 0", aok_b); end
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL rst_dok_a: got %b exp 0", dok_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rst_rdata_a: got %h exp 0", rdata_a); end
        reset = 1'b0;
        req = 1'b0;
        #1;
`ifndef RAND_DELAY_EN
        checks++; if (aok_a !== 1'b1) begin errors++; $display("FAIL post_rst_aok: got %b exp 1", aok_a); end
`endif
        step();
    endtask

    task automatic test_write_read();
        set_req(1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344);
        #1;
        checks++; if (aok_a !== 1'b1) begin errors++; $display("FAIL wr_aok: got %b exp 1", aok_a); end
        step();
        set_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL wr_dok: got %b exp 1", dok_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h exp 0", rdata_a); end
        checks++; if (aok_a !== 1'b1) begin errors++; $display("FAIL rd_aok: got %b exp 1", aok_a); end
        step();
        req = 1'b0;
        #1;
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL rd_dok: got %b exp 1", dok_a); end
        checks++; if (rdata_a !== 32'h11223344) begin errors++; $display("FAIL rd_rdata: got %h exp 11223344", rdata_a); end
        step();
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL rd_dok_end: got %b exp 0", dok_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rd_rdata_idle: got %h exp 0", rdata_a); end
        idle(6);
    endtask

    task automatic test_strobe();
        set_req(1'b1, 1'b1, 32'h10, 4'hC, 32'hAABB0000);
        step();
        set_req(1'b1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        #1;
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL strb_dok: got %b exp 1", dok_a); end
        step();
        set_req(1'b1, 1'b0, 32'h10000013, 4'h0, 32'h0);
        #1;
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL strb0_dok: got %b exp 1", dok_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL strb0_rdata: got %h exp 0", rdata_a); end
        step();
        req = 1'b0;
        #1;
        checks++; if (dok_a !== 1'b1) begin errors++; $display("FAIL strb_rd_dok: got %b exp 1", dok_a); end
        checks++; if (rdata_a !== 32'hAABB3344) begin errors++; $display("FAIL strb_rdata: got %h exp aabb3344", rdata_a); end
        idle(6);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'b1, 32'h40 + 32'(4*i), 4'hF, 32'hC0DE0000 + 32'(i));
            #1;
            checks++; if (aok_a !== 1'b1 || aok_b !== 1'b1) begin errors++; $display("FAIL preload_aok%0d: got %b%b exp 11", i, aok_a, aok_b); end
            step();
            idle(5);
        end
        for (int c = 0; c < 9; c++) begin
            if (c < 8) set_req(1'b1, 1'b0, 32'h40 + 32'(4*c), 4'h0, 32'h0);
            else req = 1'b0;
            #1;
            if (c < 8) begin
                checks++; if (aok_a !== 1'b1) begin errors++; $display("FAIL b2b_aok%0d: got %b exp 1", c, aok_a); end
            end
            if (c > 0) begin
                checks++; if (dok_a !== 1'b1 || rdata_a !== 32'hC0DE0000 + 32'(c-1))
                    begin errors++; $display("FAIL b2b_resp%0d: got dok=%b rdata=%h exp dok=1 rdata=%h", c, dok_a, rdata_a, 32'hC0DE0000 + 32'(c-1)); end
            end
            step();
        end
        #1;
        checks++; if (dok_a !== 1'b0) begin errors++; $display("FAIL b2b_end_dok: got %b exp 0", dok_a); end
        idle(8);
    endtask

    task automatic test_delay4();
        set_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        #1;
        checks++; if (aok_b !== 1'b1) begin errors++; $display("FAIL d4_aok0: got %b exp 1", aok_b); end
        step();
        addr = 32'h44;
        #1;
        checks++; if (aok_b !== 1'b1) begin errors++; $display("FAIL d4_aok1: got %b exp 1", aok_b); end
        checks++; if (dok_b !== 1'b0) begin errors++; $display("FAIL d4_dok1: got %b exp 0", dok_b); end
        step();
        for (int c = 2; c < 4; c++) begin
            #1;
            checks++; if (aok_b !== 1'b0 || dok_b !== 1'b0) begin errors++; $display("FAIL d4_full%0d: got aok=%b dok=%b exp 0 0", c, aok_b, dok_b); end
            step();
        end
        #1;
        checks++; if (dok_b !== 1'b1 || rdata_b !== 32'hC0DE0000) begin errors++; $display("FAIL d4_resp0: got dok=%b rdata=%h exp 1 c0de0000", dok_b, rdata_b); end
        checks++; if (aok_b !== 1'b0) begin errors++; $display("FAIL d4_aok_pop: got %b exp 0", aok_b); end
        step();
        req = 1'b0;
        #1;
        checks++; if (dok_b !== 1'b1 || rdata_b !== 32'hC0DE0001) begin errors++; $display("FAIL d4_resp1: got dok=%b rdata=%h exp 1 c0de0001", dok_b, rdata_b); end
        checks++; if (aok_b !== 1'b1) begin errors++; $display("FAIL d4_aok5: got %b exp 1", aok_b); end
        step();
        checks++; if (dok_b !== 1'b0) begin errors++; $display("FAIL d4_end: got %b exp 0", dok_b); end
        idle(8);
    endtask

    task automatic test_reset_mid();
        set_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        #1;
        checks++; if (aok_b !== 1'b1) begin errors++; $display("FAIL rm_aok0: got %b exp 1", aok_b); end
        step();
        addr = 32'h44;
        #1;
        checks++; if (aok_b !== 1'b1) begin errors++; $display("FAIL rm_aok1: got %b exp 1", aok_b); end
        step();
        reset = 1'b1;
        set_req(1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
        #1;
        checks++; if (aok_a !== 1'b0 || aok_b !== 1'b0) begin errors++; $display("FAIL rm_rst_aok: got %b%b exp 00", aok_a, aok_b); end
        checks++; if (dok_a !== 1'b0 || dok_b !== 1'b0) begin errors++; $display("FAIL rm_rst_dok: got %b%b exp 00", dok_a, dok_b); end
        step();
        reset = 1'b0;
        req = 1'b0;
        #1;
        checks++; if (aok_a !== 1'b1 || aok_b !== 1'b1) begin errors++; $display("FAIL rm_post_aok: got %b%b exp 11", aok_a, aok_b); end
        for (int c = 0; c < 6; c++) begin
            checks++; if (dok_a !== 1'b0 || dok_b !== 1'b0) begin errors++; $display("FAIL rm_stale_dok%0d: got %b%b exp 00", c, dok_a, dok_b); end
            step();
        end
        set_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        step();
        req = 1'b0;
        #1;
        checks++; if (dok_a !== 1'b1 || rdata_a !== 32'hC0DE0000) begin errors++; $display("FAIL rm_no_write: got dok=%b rdata=%h exp 1 c0de0000", dok_a, rdata_a); end
        idle(8);
    endtask

    task automatic test_random();
        logic [31:0] mdl [16];
        logic [31:0] expq [$];
        logic [31:0] e, wd;
        logic [3:0] ws;
        logic is_wr;
        int k = 0, acc = 0, resp = 0, cyc = 0;
        while ((acc < 216 || expq.size() != 0) && cyc < 6000) begin
            if (acc < 216) begin
                is_wr = acc < 16 ? 1'b1 : ($urandom_range(0, 1) == 1);
                k = acc < 16 ? acc : int'($urandom_range(0, 15));
                ws = acc < 16 ? 4'hF : 4'($urandom_range(0, 15));
                wd = $urandom;
                set_req(acc < 16 || $urandom_range(0, 4) != 0, is_wr, 32'h200 + 32'(k*4) + 32'($urandom_range(0, 3)), ws, wd);
            end else req = 1'b0;
            #1;
            if (dok_a) begin
                resp++;
                checks++;
                if (expq.size() == 0) begin errors++; $display("FAIL rnd_extra_dok: got dok=1 exp 0 at cycle %0d", cyc); end
                else begin
                    e = expq.pop_front();
                    if (rdata_a !== e) begin errors++; $display("FAIL rnd_rdata: got %h exp %h at cycle %0d", rdata_a, e, cyc); end
                end
            end else begin
                checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rnd_idle_rdata: got %h exp 0", rdata_a); end
            end
`ifdef RAND_DELAY_EN
            checks++; if (aok_a === 1'b1 && dut_a.lfsr_q[1:0] == 2'b00) begin errors++; $display("FAIL rnd_gate: got aok=1 exp 0 with lfsr[1:0]=00"); end
`endif
            if (req && aok_a) begin
                acc++;
                if (wr) begin
                    for (int b = 0; b < 4; b++) if (ws[b]) mdl[k][8*b +: 8] = wd[8*b +: 8];
                    expq.push_back(32'h0);
                end else expq.push_back(mdl[k]);
            end
            step();
            cyc++;
        end
        req = 1'b0;
        checks++; if (cyc >= 6000) begin errors++; $display("FAIL rnd_timeout: got %0d pending exp 0", expq.size()); end
        checks++; if (resp != acc) begin errors++; $display("FAIL rnd_count: got %0d responses exp %0d", resp, acc); end
    endtask

    initial begin
        test_reset();
`ifndef RAND_DELAY_EN
        test_write_read();
        test_strobe();
        test_back_to_back();
        test_delay4();
        test_reset_mid();
`endif
        idle(8);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
